ysyx_bus_arb: RTL
=================

# ysyx_bus_arb

Two-master memory-bus arbiter between the IFU (instruction fetch, read-only) and the LSU (load/store, read and write) and the single downstream memory slave. It latches one request at a time and drives it onto an AXI-lite-style slave port, tracking the address, data and response phases. It returns the response to the owning master as a one-cycle pulse. When both masters are waiting it grants in round-robin order.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; wstrb width is DATA_W/8
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ifu_araddr  in  ADDR_W  IFU read address
- ifu_arvalid  in  1  IFU read request, level
- ifu_rdata  out  DATA_W  IFU read data, valid when ifu_rvalid
- ifu_rvalid  out  1  IFU read-done pulse
- lsu_araddr / lsu_arvalid  in  ADDR_W / 1  LSU read request
- lsu_rdata / lsu_rvalid  out  DATA_W / 1  LSU read data and done pulse
- lsu_awaddr / lsu_awvalid  in  ADDR_W / 1  LSU write request
- lsu_wdata / lsu_wstrb  in  DATA_W / DATA_W/8  LSU write data and byte strobes
- lsu_bvalid  out  1  LSU write-done pulse
- m_araddr, m_arvalid / m_arready  out / in  slave read-address channel
- m_rdata, m_rvalid / m_rready  in / out  slave read-data channel
- m_awaddr, m_awvalid / m_awready  out / in  slave write-address channel
- m_wdata, m_wstrb, m_wvalid / m_wready  out / in  slave write-data channel
- m_bvalid / m_bready  in / out  slave write-response channel
- gnt  out  2  current owner as {lsu, ifu}; 2'b00 when IDLE

## Operation
- **FSM states:** IDLE, AR, R, WA, B.
- **Request sampling:** requests are level signals and are sampled only in IDLE.
  - A master must drop its request in the cycle after its done pulse. A request still high in IDLE starts a new transaction.
- **Grant on entering a transaction:**
  - Register the address, wdata and wstrb.
  - Set gnt.
  - Update last_grant (0 = IFU, 1 = LSU).
- **Arbitration:**
  - Only one master requesting: that master wins.
  - Both requesting: the master that is not last_grant wins.
  - last_grant resets to LSU, so the IFU wins the first tie.
- **LSU request type:** lsu_awvalid and lsu_arvalid both high means write. Such a read is ignored until a later IDLE.
- **Transitions:**
  - IDLE to AR on a read grant; IDLE to WA on a write grant.
  - AR: m_arvalid=1. On m_arready go to R.
  - R: m_rready=1. On m_rvalid go to IDLE.
  - WA: m_awvalid=1 until its handshake completes, then aw_done=1. m_wvalid=1 until its handshake completes, then w_done=1.
    - The two handshakes complete in either order or in the same cycle.
    - Go to B in the cycle where both are complete, counting that cycle's handshakes.
  - B: m_bready=1. On m_bvalid go to IDLE.
- **Read completion:** ifu_rvalid/lsu_rvalid = (state==R) & m_rvalid & owner, combinational.
  - ifu_rdata and lsu_rdata pass m_rdata through unconditionally.
- **Write completion:** lsu_bvalid = (state==B) & m_bvalid.
- **Ignored fields:** slave response codes are not consumed.
- **Output stability:** m_* address, data and strb outputs come from the registers and are stable while their valid is high.

## Timing
- **Reset:**
  - State IDLE.
  - gnt=0; last_grant=LSU; aw_done and w_done cleared.
  - All m_*valid, m_rready, m_bready, ifu_rvalid, lsu_rvalid and lsu_bvalid are 0.
  - Data and address registers are 0.
- **Minimum read** (request seen in IDLE at cycle 0):
  - AR at cycle 1 with m_arvalid=1; m_arready at cycle 1.
  - R at cycle 2; m_rvalid at cycle 2 gives the done pulse at cycle 2.
  - IDLE at cycle 3; next grant at cycle 3, so the next transaction reaches AR/WA at cycle 4.
- **Minimum write:** WA at cycle 1 with both readies high, B at cycle 2, lsu_bvalid at cycle 2 at the earliest, IDLE at cycle 3.
- **Response stall:** no timeout; each state holds indefinitely while its slave handshake is outstanding.
- **Slave port protocol:**
  - Valids are never deasserted before their handshake.
  - m_arvalid and m_awvalid are never high together.
- **IDLE dwell:** IDLE lasts at least 1 cycle between transactions, so a dropped request is observed.
- **Reset mid-transaction:** return to IDLE next cycle and abandon the transaction. The slave shares rst and must reset as well.

## Test plan
- **Single IFU read:** ifu_arvalid, araddr=0x8000_0000; slave arready immediate, rdata=0x0000_0413 two cycles later.
  - Required: m_araddr=0x8000_0000 at cycle 1, gnt=01 from cycle 1.
  - Required: ifu_rvalid pulse with ifu_rdata=0x413, then gnt=00.
- **Simultaneous IFU and LSU reads** held high after reset:
  - Required grant order: IFU, LSU, IFU.
  - Required: each done pulse is exactly 1 cycle and goes to the correct master only.
- **LSU write with W before AW:** awaddr=0xA000_03F8, wdata=0x41, wstrb=0001; wready at cycle 1, awready at cycle 3.
  - Required: m_wvalid drops after cycle 1.
  - Required: WA to B after cycle 3.
  - Required: lsu_bvalid on m_bvalid; m_wstrb=0001 throughout.
- **Slave stalls:** arready low for 5 cycles, then rvalid low for 4 cycles.
  - Required: m_araddr stable throughout.
  - Required: no done pulse before m_rvalid; gnt unchanged.
- **Reset mid-transaction:** rst asserted in state R.
  - Required next cycle: all valids 0, gnt=00, no done pulse.
  - Required: after release, a tie grants the IFU first.
- **Request held after done:** ifu_arvalid held high after ifu_rvalid.
  - Required: a second read starts after one IDLE cycle.
  - Required: no overlap with the previous transaction.

Source files
------------

// File: rtl/ysyx_bus_arb_if.sv
// Signal bundle between the arbiter, its two upstream masters (IFU, LSU) and the memory slave.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface ysyx_bus_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] ifu_araddr;
    logic              ifu_arvalid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_rvalid;

    logic [ADDR_W-1:0] lsu_araddr;
    logic              lsu_arvalid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_rvalid;
    logic [ADDR_W-1:0] lsu_awaddr;
    logic              lsu_awvalid;
    logic [DATA_W-1:0] lsu_wdata;
    logic [STRB_W-1:0] lsu_wstrb;
    logic              lsu_bvalid;

    logic [ADDR_W-1:0] m_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rvalid;
    logic              m_rready;
    logic [ADDR_W-1:0] m_awaddr;
    logic              m_awvalid;
    logic              m_awready;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic              m_wvalid;
    logic              m_wready;
    logic              m_bvalid;
    logic              m_bready;

    logic [1:0]        gnt;

    modport master (
        input  ifu_araddr, ifu_arvalid,
        output ifu_rdata, ifu_rvalid,
        input  lsu_araddr, lsu_arvalid, lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb,
        output lsu_rdata, lsu_rvalid, lsu_bvalid,
        output m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid,
        output m_wdata, m_wstrb, m_wvalid, m_bready,
        input  m_arready, m_rdata, m_rvalid, m_awready, m_wready, m_bvalid,
        output gnt
    );

    modport slave (
        output ifu_araddr, ifu_arvalid,
        input  ifu_rdata, ifu_rvalid,
        output lsu_araddr, lsu_arvalid, lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb,
        input  lsu_rdata, lsu_rvalid, lsu_bvalid,
        input  m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid,
        input  m_wdata, m_wstrb, m_wvalid, m_bready,
        output m_arready, m_rdata, m_rvalid, m_awready, m_wready, m_bvalid,
        input  gnt
    );
endinterface

// File: rtl/ysyx_bus_arb.sv
// Round-robin arbiter putting one IFU or LSU transaction at a time onto an AXI-lite-style slave.
// Addresses and write data are latched at grant, so slave-side fields stay stable while valid.
module ysyx_bus_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic            clk,
    input logic            rst,
    ysyx_bus_arb_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_WA,
        S_B
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              last_lsu_q, last_lsu_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    logic ifu_req, lsu_req, pick_lsu;

    assign ifu_req  = bus.ifu_arvalid;
    assign lsu_req  = bus.lsu_arvalid | bus.lsu_awvalid;
    // On a tie the master that did not win last time goes first.
    assign pick_lsu = lsu_req & (~ifu_req | ~last_lsu_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            gnt_q      <= 2'b00;
            last_lsu_q <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            gnt_q      <= gnt_d;
            last_lsu_q <= last_lsu_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        // NOTE: every _d starts as its _q, so no branch can leave a signal unassigned (no latch).
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        gnt_d      = gnt_q;
        last_lsu_d = last_lsu_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;

        case (state_q)
            S_IDLE: begin
                if (ifu_req | lsu_req) begin
                    gnt_d      = pick_lsu ? 2'b10 : 2'b01;
                    last_lsu_d = pick_lsu;
                    wdata_d    = bus.lsu_wdata;
                    wstrb_d    = bus.lsu_wstrb;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    if (!pick_lsu) begin
                        addr_d  = bus.ifu_araddr;
                        state_d = S_AR;
                    end else if (bus.lsu_awvalid) begin
                        addr_d  = bus.lsu_awaddr;
                        state_d = S_WA;
                    end else begin
                        addr_d  = bus.lsu_araddr;
                        state_d = S_AR;
                    end
                end
            end
            S_AR: begin
                if (bus.m_arready) state_d = S_R;
            end
            S_R: begin
                if (bus.m_rvalid) begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                end
            end
            S_WA: begin
                // Either handshake may land first; both count in the cycle they occur.
                aw_done_d = aw_done_q | bus.m_awready;
                w_done_d  = w_done_q | bus.m_wready;
                if (aw_done_d && w_done_d) state_d = S_B;
            end
            S_B: begin
                if (bus.m_bvalid) begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.m_araddr  = addr_q;
    assign bus.m_awaddr  = addr_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_wstrb   = wstrb_q;
    assign bus.m_arvalid = (state_q == S_AR);
    assign bus.m_rready  = (state_q == S_R);
    assign bus.m_awvalid = (state_q == S_WA) & ~aw_done_q;
    assign bus.m_wvalid  = (state_q == S_WA) & ~w_done_q;
    assign bus.m_bready  = (state_q == S_B);

    assign bus.ifu_rdata  = bus.m_rdata;
    assign bus.lsu_rdata  = bus.m_rdata;
    assign bus.ifu_rvalid = (state_q == S_R) & bus.m_rvalid & gnt_q[0];
    assign bus.lsu_rvalid = (state_q == S_R) & bus.m_rvalid & gnt_q[1];
    assign bus.lsu_bvalid = (state_q == S_B) & bus.m_bvalid;
    assign bus.gnt        = gnt_q;
endmodule
